// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-stage state encoding and instruction constants
package cpu_fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} fetch_state_e;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_C = 32'h0000_0000;
  localparam int PC_INC = 4;
endpackage

// File: rtl/cpu_fetch_buffer.sv
// cpu_fetch_buffer: decode output register plus a 1-entry hold slot for a response that arrives under stall
module cpu_fetch_buffer
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               load,
  input  logic               save,
  input  logic               pop,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               instr_valid
);
  logic [INSTR_W-1:0] instr_d, instr_q, hold_instr_d, hold_instr_q;
  logic [ADDR_W-1:0] pc_d, pc_q, next_pc_d, next_pc_q, hold_pc_d, hold_pc_q;
  logic valid_d, valid_q, hold_full_d, hold_full_q, take_new, take_hold, keep;
  // flush wins over everything, stall only preserves when nothing new is presented
  always_comb begin
    take_new = !flush && load;
    take_hold = !flush && pop && hold_full_q;
    keep = !flush && !load && !pop && stall;
    valid_d = take_new || take_hold || (keep && valid_q);
    instr_d = take_new ? in_instr : take_hold ? hold_instr_q : keep ? instr_q : NOP_INSTR;
    pc_d = take_new ? in_pc : take_hold ? hold_pc_q : keep ? pc_q : '0;
    next_pc_d = take_new ? in_pc + ADDR_W'(PC_INC) : take_hold ? hold_pc_q + ADDR_W'(PC_INC) : keep ? next_pc_q : '0;
    hold_full_d = !flush && (save || (hold_full_q && !pop));
    hold_instr_d = save ? in_instr : hold_instr_q;
    hold_pc_d = save ? in_pc : hold_pc_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q <= '0;
      next_pc_q <= '0;
      valid_q <= 1'b0;
      hold_full_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q <= pc_d;
      next_pc_q <= next_pc_d;
      valid_q <= valid_d;
      hold_full_q <= hold_full_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q <= hold_pc_d;
    end
  end
  assign instr = instr_q;
  assign pc = pc_q;
  assign next_pc = next_pc_q;
  assign instr_valid = valid_q;
endmodule

// File: rtl/cpu_fetch_stage.sv
// cpu_fetch_stage: PC and one-outstanding fetch FSM feeding decode; define CPU_FETCH_PERF_EN for perf counters
module cpu_fetch_stage
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BOOT_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  next_PC,
  output logic               instr_valid
`ifdef CPU_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_dropped
`endif
);
  fetch_state_e state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q, req_pc_d, req_pc_q;
  logic req_valid, load, save, pop, drop, fire;
  always_comb begin
    state_d = state_q;
    req_valid = 1'b0;
    load = 1'b0;
    save = 1'b0;
    pop = 1'b0;
    drop = 1'b0;
    case (state_q)
      REQ: begin
        req_valid = 1'b1;
        state_d = !imem_req_ready ? REQ : redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        drop = redirect_valid && imem_rsp_valid;
        save = !redirect_valid && imem_rsp_valid && stall;
        load = !redirect_valid && imem_rsp_valid && !stall;
        req_valid = load;
        state_d = redirect_valid ? (imem_rsp_valid ? REQ : DROP) : save ? HOLD : !load ? WAIT : imem_req_ready ? WAIT : REQ;
      end
      HOLD: begin
        pop = !redirect_valid && !stall;
        state_d = (redirect_valid || !stall) ? REQ : HOLD;
      end
      DROP: begin
        drop = imem_rsp_valid;
        state_d = imem_rsp_valid ? REQ : DROP;
      end
    endcase
    req_valid = req_valid && !reset;
    fire = req_valid && imem_req_ready;
    pc_d = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : fire ? pc_q + ADDR_W'(PC_INC) : pc_q;
    req_pc_d = fire ? pc_q : req_pc_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= REQ;
      pc_q <= BOOT_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end
  assign imem_req_valid = req_valid;
  assign imem_req_addr = pc_q;
  cpu_fetch_buffer #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_buf (
    .clock(clock), .reset(reset), .stall(stall), .flush(redirect_valid),
    .load(load), .save(save), .pop(pop), .in_instr(imem_rsp_data), .in_pc(req_pc_q),
    .instr(instr), .pc(pc), .next_pc(next_PC), .instr_valid(instr_valid)
  );
`ifdef CPU_FETCH_PERF_EN
  logic [31:0] perf_fetched_d, perf_fetched_q, perf_stall_d, perf_stall_q;
  logic [15:0] perf_dropped_d, perf_dropped_q;
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(!(&perf_fetched_q) && (load || pop));
    perf_stall_d = perf_stall_q + 32'(!(&perf_stall_q) && stall);
    perf_dropped_d = perf_dropped_q + 16'(!(&perf_dropped_q) && drop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q <= perf_stall_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end
  assign perf_fetched = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
  assign perf_dropped = perf_dropped_q;
`endif
endmodule
